uart_cfg_dump_tx: RTL and testbench
===================================

Name: uart_cfg_dump_tx

Overview:
Parametrised UART transmitter that serialises a configuration snapshot as a framed multi-byte packet.
- Packet: header 0xA5, NBYTES payload bytes, 1 XOR checksum byte.
- Integrates the baud divider and bit serialiser in one clock domain.
- Adds configurable parity and stop bits, request queuing, and optional periodic auto-repeat.
- Drives the board debug UART TX pin; replaces the fixed single-byte config-show path.

Parameters:
CLK_HZ, 10000000, input clock frequency in Hz
BAUD, 115200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (87 at defaults)
NBYTES, 4, payload bytes per packet, range 1..32
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
GAP_BITS, 1000, idle bit-times between packets in auto-repeat mode

Ports:
clk10mhz  in  1  system clock at CLK_HZ
rst  in  1  synchronous reset, active high
cfgData  in  8*NBYTES  payload; byte k = cfgData[8k+7:8k]; byte 0 is sent first
dumpReq  in  1  one-cycle request to send one packet
autoEn  in  1  level; when 1, resend the packet every GAP_BITS bit-times after each completes
uTx  out  1  serial line, idle high
txBusy  out  1  packet in progress
dumpDone  out  1  one-cycle pulse at packet end
byteIdx  out  6  index of the byte on the line: 0 = header, 1..NBYTES = payload, NBYTES+1 = checksum

Behaviour:
- Single clock; all state changes on the rising edge of clk10mhz. rst is synchronous, active high.
- Reset values: uTx=1, txBusy=0, dumpDone=0, byteIdx=0, pending=0, state=IDLE, baud counter=0.
- Reset mid-packet aborts on the next edge and drives uTx high immediately. The truncated frame is accepted; no resume.
- State machine:
  - IDLE -> START on accept. Accept = dumpReq=1, or pending=1, or (autoEn=1 and gap expired).
  - START -> DATA -> [PARITY if PARITY!=0] -> STOP.
  - STOP -> START for the next byte if bytes remain; else -> IDLE, or -> GAP if autoEn=1.
  - GAP -> IDLE after GAP_BITS*DIV cycles.
  - GAP -> START immediately if dumpReq arrives during GAP.
- Acceptance:
  - On acceptance, cfgData is snapshotted into an internal register.
  - The checksum is the XOR of all payload bytes from the snapshot.
  - Later changes to cfgData do not affect the packet in flight.
- Timing:
  - uTx goes low in the cycle after the accept edge.
  - Every bit lasts exactly DIV cycles. The baud counter restarts at each packet start.
  - Data bits go LSB first, 8 data bits.
  - Parity bit: even parity makes (ones in data + parity) even; odd parity makes it odd.
  - Stop bits are high for STOP_BITS*DIV cycles.
  - Bytes within a packet are back-to-back, with no extra idle.
  - Packet length = (NBYTES+2) * (10 + (PARITY!=0) + (STOP_BITS-1)) * DIV cycles.
- txBusy:
  - High from the cycle uTx first goes low through the last cycle of the final stop bit.
  - Low in the GAP state.
- dumpDone: 1-cycle pulse in the first cycle after the final stop bit, coincident with txBusy falling.
- Queuing:
  - dumpReq while busy sets pending (one deep; further requests are merged).
  - pending is served immediately after the current packet, skipping GAP.
  - pending is cleared on acceptance.
- Simultaneous events:
  - dumpReq in the same cycle as packet end is queued as pending; at most 1 idle cycle before the next start bit.
  - autoEn dropping during GAP returns the block to IDLE at gap expiry with no new packet.
  - autoEn dropping mid-packet finishes the current packet only.
- byteIdx holds its last value in IDLE and GAP, and resets to 0 at each packet start.

Test Plan:
1. Defaults, cfgData=0x12345678, dumpReq pulse -> uTx bytes A5,78,56,34,12,08 in order; first start bit one cycle after the request; each bit 87 cycles; dumpDone at exactly 6*10*87=5220 cycles after the first start bit.
2. PARITY=2, STOP_BITS=2, NBYTES=1, cfgData=0x07 -> frames A5 (parity 0), 07 (parity 1), 07 checksum (parity 1); 12-bit frames of 87 cycles per bit; checksum 0x07.
3. dumpReq pulsed 3 times mid-packet -> exactly one extra packet, starting ≤1 cycle after dumpDone; txBusy high throughout.
4. autoEn=1, GAP_BITS=4 -> packets repeat with 4*87=348 cycles of idle high between dumpDone and the next start bit; autoEn=0 during GAP -> no further packet.
5. rst=1 asserted during payload byte 2 -> next edge: uTx=1, txBusy=0, byteIdx=0, pending cleared; a fresh dumpReq sends a complete packet correctly.
6. cfgData changed on the cycle after accept -> transmitted payload and checksum reflect the snapshot value only.

Source files
------------

// File: rtl/uart_cfg_dump_tx.sv
// uart_cfg_dump_tx: framed config-snapshot UART transmitter with parity, stop bits, request queuing and auto-repeat
module uart_cfg_dump_tx #(
    parameter int CLK_HZ    = 10000000,
    parameter int BAUD      = 115200,
    parameter int NBYTES    = 4,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int GAP_BITS  = 1000
) (
    input  logic                clk10mhz,
    input  logic                rst,
    input  logic [8*NBYTES-1:0] cfgData,
    input  logic                dumpReq,
    input  logic                autoEn,
    output logic                uTx,
    output logic                txBusy,
    output logic                dumpDone,
    output logic [5:0]          byteIdx
);
    localparam int DIV    = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int GAPCYC = GAP_BITS * DIV;
    localparam int BW     = $clog2(DIV + 1);
    localparam int GW     = $clog2(GAPCYC + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, GAP} stateT;

    stateT               state, nxt;
    logic [BW-1:0]       baudCnt;
    logic [GW-1:0]       gapCnt;
    logic [2:0]          bitCnt;
    logic [8*NBYTES-1:0] snap;
    logic [7:0]          csum, cfgXor, curByte;
    logic                pending, bitEnd, gapEnd, frameEnd, lastByte, packetEnd, accept, parityBit;

    always_comb begin
        cfgXor = '0;
        for (int i = 0; i < NBYTES; i++) cfgXor = cfgXor ^ cfgData[8*i +: 8];
    end

    assign bitEnd    = baudCnt == BW'(DIV - 1);
    assign gapEnd    = gapCnt == GW'(GAPCYC - 1);
    assign lastByte  = byteIdx == 6'(NBYTES + 1);
    assign curByte   = byteIdx == 6'd0 ? 8'hA5 : lastByte ? csum : snap[7:0];
    assign parityBit = ^curByte ^ (PARITY == 1);
    assign frameEnd  = state == STOP && bitEnd && bitCnt == 3'(STOP_BITS - 1);
    assign packetEnd = frameEnd && lastByte;
    assign accept    = (state == IDLE || state == GAP) && nxt == START;
    assign txBusy    = state == START || state == DATA || state == PAR || state == STOP;
    assign uTx       = state == START ? 1'b0 : state == DATA ? curByte[bitCnt] : state == PAR ? parityBit : 1'b1;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (dumpReq || pending) nxt = START;
            START:   if (bitEnd) nxt = DATA;
            DATA:    if (bitEnd && bitCnt == 3'd7) nxt = PARITY != 0 ? PAR : STOP;
            PAR:     if (bitEnd) nxt = STOP;
            STOP:    if (frameEnd) nxt = !lastByte ? START : (autoEn && !pending && !dumpReq) ? GAP : IDLE;
            GAP:     if (dumpReq || pending || (gapEnd && autoEn)) nxt = START;
                     else if (gapEnd) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk10mhz) begin
        if (rst) begin
            state    <= IDLE;
            baudCnt  <= '0;
            gapCnt   <= '0;
            bitCnt   <= '0;
            byteIdx  <= '0;
            pending  <= 1'b0;
            dumpDone <= 1'b0;
            snap     <= '0;
            csum     <= '0;
        end else begin
            state    <= nxt;
            dumpDone <= packetEnd;
            pending  <= !accept && (pending || (dumpReq && txBusy));
            baudCnt  <= (accept || bitEnd || !txBusy) ? '0 : baudCnt + 1'b1;
            gapCnt   <= state == GAP ? gapCnt + 1'b1 : '0;
            if (bitEnd) bitCnt <= nxt == state ? bitCnt + 3'd1 : 3'd0;
            if (accept) begin
                byteIdx <= '0;
                snap    <= cfgData;
                csum    <= cfgXor;
            end else if (frameEnd && !lastByte) begin
                byteIdx <= byteIdx + 6'd1;
                if (byteIdx != 6'd0) snap <= snap >> 8;
            end
        end
    end
endmodule

// File: tb/tb_uart_cfg_dump_tx.sv
// tb_uart_cfg_dump_tx: directed/randomized bench comparing the serial line against a byte-level frame model
module tb_uart_cfg_dump_tx;
    localparam int DIV  = 87;
    localparam int GAPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cfgA;
    logic [7:0]  cfgB;
    logic        reqA, reqB, autoA, autoB;
    logic        txA, busyA, doneA, txB, busyB, doneB;
    logic [5:0]  idxA, idxB;
    int          tests = 0, fails = 0;
    int          expBits[$];

    always #50 clk = ~clk;

    uart_cfg_dump_tx #(.GAP_BITS(GAPB)) dutA (
        .clk10mhz(clk), .rst(rst), .cfgData(cfgA), .dumpReq(reqA), .autoEn(autoA),
        .uTx(txA), .txBusy(busyA), .dumpDone(doneA), .byteIdx(idxA)
    );

    uart_cfg_dump_tx #(.NBYTES(1), .PARITY(2), .STOP_BITS(2), .GAP_BITS(GAPB)) dutB (
        .clk10mhz(clk), .rst(rst), .cfgData(cfgB), .dumpReq(reqB), .autoEn(autoB),
        .uTx(txB), .txBusy(busyB), .dumpDone(doneB), .byteIdx(idxB)
    );

    function automatic logic lineOf(input int w);
        return w != 0 ? txB : txA;
    endfunction

    function automatic logic busyOf(input int w);
        return w != 0 ? busyB : busyA;
    endfunction

    function automatic logic doneOf(input int w);
        return w != 0 ? doneB : doneA;
    endfunction

    function automatic int idxOf(input int w);
        return w != 0 ? int'(idxB) : int'(idxA);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected line level for every bit-time of one packet
    task automatic model(input int nb, input int par, input int stops, input logic [31:0] data);
        int bytes[$];
        int x, b8, ones;
        expBits.delete();
        x = 0;
        bytes.push_back('hA5);
        for (int k = 0; k < nb; k++) begin
            b8 = int'((data >> (8 * k)) & 32'hFF);
            bytes.push_back(b8);
            x = x ^ b8;
        end
        bytes.push_back(x);
        foreach (bytes[j]) begin
            ones = 0;
            expBits.push_back(0);
            for (int b = 0; b < 8; b++) begin
                expBits.push_back((bytes[j] >> b) & 1);
                ones += (bytes[j] >> b) & 1;
            end
            if (par == 2) expBits.push_back(ones % 2);
            if (par == 1) expBits.push_back(1 - ones % 2);
            for (int s = 0; s < stops; s++) expBits.push_back(1);
        end
    endtask

    task automatic checkPacket(input string tag, input int w, input logic [31:0] data, input int maxWait, output int waited);
        int ok, fl;
        model(w != 0 ? 1 : 4, w != 0 ? 2 : 0, w != 0 ? 2 : 1, data);
        fl = w != 0 ? 12 : 10;
        waited = 0;
        while (lineOf(w) === 1'b1 && waited < maxWait) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, " start"}, 32'(lineOf(w)), 32'd0);
        if (lineOf(w) !== 1'b0) return;
        foreach (expBits[i]) begin
            ok = 1;
            for (int c = 0; c < DIV; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (lineOf(w) !== 1'(expBits[i]) || busyOf(w) !== 1'b1 || doneOf(w) !== 1'b0 || idxOf(w) != i / fl) ok = 0;
            end
            chk($sformatf("%s bit%0d", tag, i), 32'(ok), 32'd1);
        end
        @(negedge clk);
        chk({tag, " done"}, {29'd0, doneOf(w), busyOf(w), lineOf(w)}, 32'b101);
    endtask

    task automatic pulse(input int w);
        if (w != 0) reqB = 1'b1;
        else reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        reqB = 1'b0;
    endtask

    task automatic quiet(input string tag, input int w, input int n);
        int ok;
        ok = 1;
        repeat (n) begin
            @(negedge clk);
            if (lineOf(w) !== 1'b1 || busyOf(w) !== 1'b0) ok = 0;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        #9000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, n;
        logic [31:0] d;
        reqA = 1'b0; reqB = 1'b0; autoA = 1'b0; autoB = 1'b0; cfgA = '0; cfgB = '0;
        repeat (3) @(negedge clk);
        chk("reset A", {23'd0, txA, busyA, doneA, idxA}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd0});
        chk("reset B", {23'd0, txB, busyB, doneB, idxB}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd0});
        rst = 1'b0;
        quiet("idle A", 0, 20);

        cfgA = 32'h12345678;
        pulse(0);
        checkPacket("t1", 0, 32'h12345678, 0, w);
        chk("t1 latency", 32'(w), 32'd0);

        cfgB = 8'h07;
        pulse(1);
        checkPacket("t2", 1, 32'h07, 0, w);

        d = $urandom;
        cfgA = d;
        reqA = 1'b1;
        @(negedge clk);
        reqA = 1'b0;
        cfgA = $urandom;
        checkPacket("t6 snapshot", 0, d, 0, w);

        d = $urandom;
        cfgA = d;
        pulse(0);
        fork
            checkPacket("t3a", 0, d, 0, w);
            begin
                repeat (500) @(negedge clk);
                repeat (3) begin
                    reqA = 1'b1;
                    @(negedge clk);
                    reqA = 1'b0;
                    repeat (700) @(negedge clk);
                end
            end
        join
        checkPacket("t3b", 0, d, 1, w);
        chk("t3 restart", 32'(w <= 1), 32'd1);
        quiet("t3 single", 0, 300);

        autoA = 1'b1;
        d = $urandom;
        cfgA = d;
        pulse(0);
        checkPacket("t4a", 0, d, 0, w);
        checkPacket("t4b", 0, d, GAPB * DIV + 10, w);
        chk("t4 gap", 32'(w), 32'(GAPB * DIV));
        repeat (100) @(negedge clk);
        autoA = 1'b0;
        quiet("t4 stop", 0, GAPB * DIV + 200);

        cfgA = $urandom;
        pulse(0);
        n = 0;
        while (idxA !== 6'd2 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reach", 32'(idxA), 32'd2);
        pulse(0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5 reset", {23'd0, txA, busyA, doneA, idxA}, {23'd0, 1'b1, 1'b0, 1'b0, 6'd0});
        rst = 1'b0;
        quiet("t5 no pending", 0, 200);
        d = $urandom;
        cfgA = d;
        pulse(0);
        checkPacket("t5 fresh", 0, d, 0, w);

        d = 32'($urandom_range(0, 255));
        cfgB = d[7:0];
        pulse(1);
        fork
            checkPacket("t7a", 1, d, 0, w);
            begin
                repeat (3 * 12 * DIV - 1) @(negedge clk);
                reqB = 1'b1;
                @(negedge clk);
                reqB = 1'b0;
            end
        join
        checkPacket("t7b", 1, d, 1, w);
        chk("t7 restart", 32'(w <= 1), 32'd1);

        autoB = 1'b1;
        d = 32'($urandom_range(0, 255));
        cfgB = d[7:0];
        pulse(1);
        fork
            checkPacket("t8", 1, d, 0, w);
            begin
                repeat (1000) @(negedge clk);
                autoB = 1'b0;
            end
        join
        quiet("t8 stop", 1, GAPB * DIV + 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
